// File: rtl/cc_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : cc_switch_conditioner
//  Purpose  : Front end for cruise_control. Synchronises and debounces the raw
//             steering-column and brake-pedal switch levels. Arbitrates between
//             them and emits clean single-cycle command pulses. Accel and coast
//             auto-repeat while held. The brake locks out everything except
//             cancel.
//  Ports    : clock        - system clock, rising edge
//             reset        - asynchronous, active-low reset
//             *_raw        - raw asynchronous switch levels, active-high
//                            (set, accel, coast, cancel, resume, brake)
//             set/accel/coast/cancel/resume/brake
//                          - registered one-cycle command pulses, at most
//                            one per cycle
//             brake_held   - debounced brake level
//             conflict     - accel and coast both debounced-high
//  Revision : 1.0  initial release
// ============================================================================
module cc_switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic set_raw,
  input  logic accel_raw,
  input  logic coast_raw,
  input  logic cancel_raw,
  input  logic resume_raw,
  input  logic brake_raw,
  output logic set,
  output logic accel,
  output logic coast,
  output logic cancel,
  output logic resume,
  output logic brake,
  output logic brake_held,
  output logic conflict
);

  // Switch indices. Accel and coast are 0 and 1 so the repeat generate can
  // index the switch vectors directly.
  localparam int c_N_SW   = 6;
  localparam int c_ACCEL  = 0;
  localparam int c_COAST  = 1;
  localparam int c_SET    = 2;
  localparam int c_CANCEL = 3;
  localparam int c_RESUME = 4;
  localparam int c_BRAKE  = 5;

  // Terminal counts are "last value before the event". The registered output
  // stage then lands each pulse exactly on the nominal edge.
  localparam logic [CNT_W-1:0] c_DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [c_N_SW-1:0] w_raw;
  logic [c_N_SW-1:0] r_sync1;
  logic [c_N_SW-1:0] r_sync2;
  logic [c_N_SW-1:0] w_deb;
  logic [c_N_SW-1:0] r_deb_q;
  logic [c_N_SW-1:0] w_press;
  logic [1:0]        w_rpt_fire;
  logic [c_N_SW-1:0] w_ev;
  logic [c_N_SW-1:0] w_pulse_nxt;
  logic [c_N_SW-1:0] r_pulse;
  logic              w_brake_held;
  logic              w_conflict;

  assign w_raw = {brake_raw, resume_raw, cancel_raw, set_raw, coast_raw, accel_raw};

  // Two-flop synchroniser, plus a delayed copy of the debounced level for
  // edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb_q <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= w_deb;
    end
  end

  // Per-switch debounce. Any cycle where the synced value matches the
  // debounced state restarts the count, so short glitches are absorbed.
  generate
    for (genvar gi = 0; gi < c_N_SW; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_deb;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
          r_deb <= 1'b0;
        end else if (r_sync2[gi] != r_deb) begin
          if (r_cnt >= c_DEB_LAST) begin
            r_deb <= r_sync2[gi];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  // Press event is valid for the single cycle after the debounced level rises.
  assign w_press      = w_deb & ~r_deb_q;
  assign w_brake_held = w_deb[c_BRAKE];
  assign w_conflict   = w_deb[c_ACCEL] & w_deb[c_COAST];

  // Hold-to-repeat for accel (0) and coast (1). Brake or conflict forces IDLE.
  // Only a fresh press edge leaves IDLE, so clearing a conflict never
  // resumes repeating on its own.
  generate
    for (genvar gr = 0; gr < 2; gr++) begin : g_repeat
      rpt_state_t       r_state;
      rpt_state_t       w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_fire;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        if (!w_deb[gr] || w_brake_held || w_conflict) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_press[gr]) begin
                w_fire      = 1'b1;
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = '0;
              end
            end
            ST_WAIT: begin
              if (r_cnt >= c_DELAY_LAST) begin
                w_fire      = 1'b1;
                w_state_nxt = ST_REPEAT;
                w_cnt_nxt   = '0;
              end else begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (r_cnt >= c_PERIOD_LAST) begin
                w_fire    = 1'b1;
                w_cnt_nxt = '0;
              end else begin
                w_cnt_nxt = r_cnt + 1'b1;
              end
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          endcase
        end
      end

      assign w_rpt_fire[gr] = w_fire;
    end
  endgenerate

  // Lockout, then fixed-priority pick. Losers are dropped, not queued.
  always_comb begin
    w_ev             = '0;
    w_ev[c_BRAKE]    = w_press[c_BRAKE];
    w_ev[c_CANCEL]   = w_press[c_CANCEL];
    w_ev[c_SET]      = w_press[c_SET]    & ~w_brake_held;
    w_ev[c_RESUME]   = w_press[c_RESUME] & ~w_brake_held;
    w_ev[c_ACCEL]    = w_rpt_fire[c_ACCEL];
    w_ev[c_COAST]    = w_rpt_fire[c_COAST];

    w_pulse_nxt = '0;
    if (w_ev[c_BRAKE]) begin
      w_pulse_nxt[c_BRAKE] = 1'b1;
    end else if (w_ev[c_CANCEL]) begin
      w_pulse_nxt[c_CANCEL] = 1'b1;
    end else if (w_ev[c_SET]) begin
      w_pulse_nxt[c_SET] = 1'b1;
    end else if (w_ev[c_RESUME]) begin
      w_pulse_nxt[c_RESUME] = 1'b1;
    end else if (w_ev[c_ACCEL]) begin
      w_pulse_nxt[c_ACCEL] = 1'b1;
    end else if (w_ev[c_COAST]) begin
      w_pulse_nxt[c_COAST] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_pulse_nxt;
    end
  end

  assign set        = r_pulse[c_SET];
  assign accel      = r_pulse[c_ACCEL];
  assign coast      = r_pulse[c_COAST];
  assign cancel     = r_pulse[c_CANCEL];
  assign resume     = r_pulse[c_RESUME];
  assign brake      = r_pulse[c_BRAKE];
  assign brake_held = w_brake_held;
  assign conflict   = w_conflict;

endmodule
`default_nettype wire

// File: tb/tb_cc_switch_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cc_switch_conditioner
//  Purpose  : Directed, self-checking bench for cc_switch_conditioner.
//             Expected pulses are queued with their due cycle when stimulus
//             is applied. A negedge monitor compares every cycle's pulse
//             vector against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cc_switch_conditioner;

  localparam int c_DEB = 4;
  localparam int c_LAT = c_DEB + 3;
  localparam int c_RD  = 16;
  localparam int c_RP  = 8;

  // Pulse vector bit positions used by the bench.
  localparam int c_P_ACCEL  = 0;
  localparam int c_P_COAST  = 1;
  localparam int c_P_SET    = 2;
  localparam int c_P_CANCEL = 3;
  localparam int c_P_RESUME = 4;
  localparam int c_P_BRAKE  = 5;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic set_raw, accel_raw, coast_raw, cancel_raw, resume_raw, brake_raw;
  logic set, accel, coast, cancel, resume, brake, brake_held, conflict;

  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t q[$];

  logic [5:0] w_obs;
  assign w_obs = {brake, resume, cancel, set, coast, accel};

  cc_switch_conditioner #(
    .DEBOUNCE_CYCLES(c_DEB),
    .REPEAT_DELAY   (c_RD),
    .REPEAT_PERIOD  (c_RP),
    .CNT_W          (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .set_raw   (set_raw),
    .accel_raw (accel_raw),
    .coast_raw (coast_raw),
    .cancel_raw(cancel_raw),
    .resume_raw(resume_raw),
    .brake_raw (brake_raw),
    .set       (set),
    .accel     (accel),
    .coast     (coast),
    .cancel    (cancel),
    .resume    (resume),
    .brake     (brake),
    .brake_held(brake_held),
    .conflict  (conflict)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push_pulse(input int at_cyc, input int idx);
    exp_t e;
    e.cyc      = at_cyc;
    e.vec      = '0;
    e.vec[idx] = 1'b1;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every cycle, the pulse vector must equal the OR of
  // the queued entries due now (zero when nothing is due).
  always @(negedge clock) begin : mon
    logic [5:0] exp_v;
    exp_v = '0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      if (q[0].cyc == cyc) exp_v = exp_v | q[0].vec;
      void'(q.pop_front());
    end
    check("pulses", {2'b00, w_obs}, {2'b00, exp_v});
  end

  initial begin : stim
    int t0;
    {set_raw, accel_raw, coast_raw, cancel_raw, resume_raw, brake_raw} = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_state", {w_obs, brake_held, conflict}, 8'h00);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // 1: bouncing SET, then steady -> one pulse c_LAT edges after steady start
    for (int i = 0; i < 6; i++) begin
      set_raw = (i % 2 == 0);
      @(negedge clock);
    end
    set_raw = 1'b1;
    push_pulse(cyc + c_LAT, c_P_SET);
    repeat (12) @(negedge clock);
    set_raw = 1'b0;
    repeat (12) @(negedge clock);

    // 2: accel held -> t0, t0+16, then every 8, none after release
    accel_raw = 1'b1;
    t0 = cyc + c_LAT;
    push_pulse(t0, c_P_ACCEL);
    push_pulse(t0 + c_RD, c_P_ACCEL);
    push_pulse(t0 + c_RD + c_RP, c_P_ACCEL);
    push_pulse(t0 + c_RD + 2 * c_RP, c_P_ACCEL);
    push_pulse(t0 + c_RD + 3 * c_RP, c_P_ACCEL);
    repeat (c_LAT + 40) @(negedge clock);
    accel_raw = 1'b0;
    repeat (25) @(negedge clock);

    // 3: brake and cancel together -> brake only
    brake_raw  = 1'b1;
    cancel_raw = 1'b1;
    push_pulse(cyc + c_LAT, c_P_BRAKE);
    repeat (10) @(negedge clock);
    check("brake_held_on", {7'd0, brake_held}, 8'h01);
    cancel_raw = 1'b0;
    repeat (10) @(negedge clock);

    // 4: lockout - resume discarded, cancel passes
    resume_raw = 1'b1;
    repeat (12) @(negedge clock);
    resume_raw = 1'b0;
    repeat (10) @(negedge clock);
    cancel_raw = 1'b1;
    push_pulse(cyc + c_LAT, c_P_CANCEL);
    repeat (10) @(negedge clock);
    check("brake_held_still", {7'd0, brake_held}, 8'h01);
    cancel_raw = 1'b0;
    brake_raw  = 1'b0;
    repeat (10) @(negedge clock);
    check("brake_held_off", {7'd0, brake_held}, 8'h00);

    // 5: conflict stops repeat; needs fresh accel press afterwards
    accel_raw = 1'b1;
    t0 = cyc + c_LAT;
    push_pulse(t0, c_P_ACCEL);
    repeat (12) @(negedge clock);
    coast_raw = 1'b1;
    repeat (9) @(negedge clock);
    check("conflict_on", {7'd0, conflict}, 8'h01);
    repeat (16) @(negedge clock);
    coast_raw = 1'b0;
    repeat (10) @(negedge clock);
    check("conflict_off", {7'd0, conflict}, 8'h00);
    repeat (20) @(negedge clock);
    accel_raw = 1'b0;
    repeat (10) @(negedge clock);
    accel_raw = 1'b1;
    push_pulse(cyc + c_LAT, c_P_ACCEL);
    repeat (8) @(negedge clock);
    accel_raw = 1'b0;
    repeat (25) @(negedge clock);

    // 6: reset mid-REPEAT with accel still high
    accel_raw = 1'b1;
    t0 = cyc + c_LAT;
    push_pulse(t0, c_P_ACCEL);
    push_pulse(t0 + c_RD, c_P_ACCEL);
    repeat (c_LAT + 20) @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_mid_repeat", {w_obs, brake_held, conflict}, 8'h00);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    push_pulse(cyc + c_LAT, c_P_ACCEL);
    repeat (8) @(negedge clock);
    accel_raw = 1'b0;
    repeat (25) @(negedge clock);

    check("queue_drained", 8'(q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
